// File: rtl/cpu_multi_cycle_v1_pkg.sv
// Shared definitions for the multicycle RV32I-subset core.
// Holds the opcode and funct3 constants, the FSM state encoding, the ALU
// operation set, the immediate formats and the helpers that decode them.
package pkg_cpu_defs;

    // Major opcodes of the supported instruction classes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_fmt_t;

    // Sign-extended immediate of the requested format; B and J have bit0 = 0.
    function automatic logic [31:0] imm_ext(input logic [31:0] ir, input imm_fmt_t fmt);
        logic [31:0] imm;
        imm = {{20{ir[31]}}, ir[31:20]};
        case (fmt)
            IMM_I: imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

    // ALU operation for R/I arithmetic. sub_sel is funct7[5] for R-type and
    // forced low for I-type (there is no "subi"). Unsupported funct3 values
    // fall back to add.
    function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic sub_sel);
        alu_op_t op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD_SUB: op = sub_sel ? ALU_SUB : ALU_ADD;
            F3_SLT:     op = ALU_SLT;
            F3_XOR:     op = ALU_XOR;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_multi_cycle_v1_reg_file.sv
// General-purpose register file: two asynchronous read ports, one
// synchronous write port. Register 0 is hardwired to zero and ignores writes.
// Ports:
//   clk, srst              clock, synchronous active-high reset (clears all)
//   rs1_addr / rs1_data    read port 1
//   rs2_addr / rs2_data    read port 2
//   wr_en, wr_addr, wr_data write port, committed on the rising edge
module cpu_reg_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_flat[gi] = '0;
            end else begin : g_store
                logic [DATA_WIDTH-1:0] q_reg;
                always_ff @(posedge clk) begin
                    if (srst) begin
                        q_reg <= '0;
                    end else if (wr_en && (wr_addr == REG_ADDR_WIDTH'(gi))) begin
                        q_reg <= wr_data;
                    end
                end
                assign regs_flat[gi] = q_reg;
            end
        end
    endgenerate

    assign rs1_data = regs_flat[rs1_addr];
    assign rs2_data = regs_flat[rs2_addr];

endmodule

// File: rtl/cpu_multi_cycle_v1.sv
// Multicycle RV32I-subset core with a single unified memory port.
// Each instruction walks FETCH -> DECODE -> ... -> FETCH under one FSM and
// shares a single ALU for PC+4, branch/jump targets, addresses and results.
// Ports:
//   sys_clk       system clock (rising edge)
//   sys_rst       synchronous active-high reset
//   mem_data_out  memory read data for mem_addr (combinational memory)
//   mem_wr_en     memory write strobe (MEMWRITE cycle only)
//   mem_addr      byte address; memory decodes bits [31:2]
//   mem_data_in   memory write data
module cpu_multi_cycle_v1
    import pkg_cpu_defs::*;
#(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in
);

    state_t                  state_reg,   state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg,      pc_next;
    logic [ADDR_WIDTH-1:0]   old_pc_reg,  old_pc_next;
    logic [DATA_WIDTH-1:0]   ir_reg,      ir_next;
    logic [DATA_WIDTH-1:0]   a_reg,       a_next;
    logic [DATA_WIDTH-1:0]   wd_reg,      wd_next;
    logic [DATA_WIDTH-1:0]   alu_out_reg, alu_out_next;
    logic [DATA_WIDTH-1:0]   data_reg,    data_next;

    // Instruction fields
    logic [6:0]                     opcode;
    logic [2:0]                     funct3;
    logic                           funct7_b5;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [DATA_WIDTH-1:0]          imm_i, imm_s, imm_b, imm_j;

    assign opcode    = ir_reg[6:0];
    assign funct3    = ir_reg[14:12];
    assign funct7_b5 = ir_reg[30];
    assign rd_idx    = ir_reg[7  +: REG_FILE_ADDR_WIDTH];
    assign rs1_idx   = ir_reg[15 +: REG_FILE_ADDR_WIDTH];
    assign rs2_idx   = ir_reg[20 +: REG_FILE_ADDR_WIDTH];

    assign imm_i = DATA_WIDTH'(imm_ext(32'(ir_reg), IMM_I));
    assign imm_s = DATA_WIDTH'(imm_ext(32'(ir_reg), IMM_S));
    assign imm_b = DATA_WIDTH'(imm_ext(32'(ir_reg), IMM_B));
    assign imm_j = DATA_WIDTH'(imm_ext(32'(ir_reg), IMM_J));

    // Register file
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
    logic                  rf_wr_en;
    logic [DATA_WIDTH-1:0] rf_wr_data;

    cpu_reg_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_FILE_ADDR_WIDTH)
    ) u_reg_file (
        .clk      (sys_clk),
        .srst     (sys_rst),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (rf_wr_en),
        .wr_addr  (rd_idx),
        .wr_data  (rf_wr_data)
    );

    // ALU operand selection, driven purely by the current state
    logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
    alu_op_t               alu_op;
    logic                  alu_zero;

    always_comb begin
        alu_a  = DATA_WIDTH'(pc_reg);
        alu_b  = DATA_WIDTH'(4);
        alu_op = ALU_ADD;
        case (state_reg)
            S_DECODE: begin
                // Branch target is precomputed speculatively for every opcode
                alu_a = DATA_WIDTH'(old_pc_reg);
                alu_b = imm_b;
            end
            S_MEMADR: begin
                alu_a = a_reg;
                alu_b = (opcode == OP_STORE) ? imm_s : imm_i;
            end
            S_EXECR: begin
                alu_a  = a_reg;
                alu_b  = wd_reg;
                alu_op = alu_op_decode(funct3, funct7_b5);
            end
            S_EXECI: begin
                alu_a  = a_reg;
                alu_b  = imm_i;
                alu_op = alu_op_decode(funct3, 1'b0);
            end
            S_BRANCH: begin
                alu_a  = a_reg;
                alu_b  = wd_reg;
                alu_op = ALU_SUB;
            end
            S_JAL: begin
                alu_a = DATA_WIDTH'(old_pc_reg);
                alu_b = imm_j;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_op)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = alu_a + alu_b;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg   <= S_FETCH;
            pc_reg      <= '0;
            old_pc_reg  <= '0;
            ir_reg      <= '0;
            a_reg       <= '0;
            wd_reg      <= '0;
            alu_out_reg <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            old_pc_reg  <= old_pc_next;
            ir_reg      <= ir_next;
            a_reg       <= a_next;
            wd_reg      <= wd_next;
            alu_out_reg <= alu_out_next;
            data_reg    <= data_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        old_pc_next  = old_pc_reg;
        ir_next      = ir_reg;
        a_next       = a_reg;
        wd_next      = wd_reg;
        alu_out_next = alu_out_reg;
        data_next    = data_reg;
        rf_wr_en     = 1'b0;
        rf_wr_data   = alu_out_reg;

        case (state_reg)
            S_FETCH: begin
                ir_next     = mem_data_out;
                old_pc_next = pc_reg;
                pc_next     = ADDR_WIDTH'(alu_result);
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                a_next       = rs1_data;
                wd_next      = rs2_data;
                alu_out_next = alu_result;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = ((funct3 == F3_BEQ) || (funct3 == F3_BNE))
                                                    ? S_BRANCH : S_FETCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_out_next = alu_result;
                state_next   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                data_next  = mem_data_out;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                rf_wr_en   = 1'b1;
                rf_wr_data = data_reg;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_out_next = alu_result;
                state_next   = S_ALUWB;
            end
            S_ALUWB: begin
                rf_wr_en   = 1'b1;
                rf_wr_data = alu_out_reg;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                if (((funct3 == F3_BEQ) && alu_zero) || ((funct3 == F3_BNE) && !alu_zero)) begin
                    pc_next = ADDR_WIDTH'(alu_out_reg);
                end
                state_next = S_FETCH;
            end
            S_JAL: begin
                // The ALU is busy with the target, but pc_reg already holds
                // OldPC+4 from FETCH, so it serves directly as the link value.
                pc_next    = ADDR_WIDTH'(alu_result);
                rf_wr_en   = 1'b1;
                rf_wr_data = DATA_WIDTH'(pc_reg);
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Memory port; forced idle while reset is held so an aborted store
    // never reaches memory.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_addr    = pc_reg;
        mem_data_in = '0;
        if (sys_rst) begin
            mem_addr = '0;
        end else begin
            case (state_reg)
                S_MEMREAD: mem_addr = ADDR_WIDTH'(alu_out_reg);
                S_MEMWRITE: begin
                    mem_addr    = ADDR_WIDTH'(alu_out_reg);
                    mem_data_in = wd_reg;
                    mem_wr_en   = 1'b1;
                end
                default: mem_addr = pc_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multi_cycle_v1.sv
// Self-checking bench for cpu_multi_cycle_v1. Programs are loaded into a
// behavioural unified memory; every expected store (address, data, cycle)
// is queued when a program is loaded and a negedge monitor compares each
// memory write the core issues against the head of the queue.
module tb_cpu_multi_cycle_v1;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] mem_data_out;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;

    cpu_multi_cycle_v1 #(
        .ADDR_WIDTH          (32),
        .DATA_WIDTH          (32),
        .REG_FILE_ADDR_WIDTH (5)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .mem_data_out (mem_data_out),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Unified memory: 64 words, combinational read, write on the clock edge
    logic [31:0] mem [64];
    assign mem_data_out = mem[mem_addr[7:2]];
    always @(posedge sys_clk) begin
        if (mem_wr_en) mem[mem_addr[7:2]] = mem_data_in;
    end

    // Cycle 1 is the first FETCH after reset is released
    int cyc;
    always @(posedge sys_clk) begin
        if (sys_rst) cyc <= 1;
        else         cyc <= cyc + 1;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at_cyc;   // 0 = timing not checked
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data, input int at_cyc);
        exp_t e;
        e.addr   = addr;
        e.data   = data;
        e.at_cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: one line per observed store
    always @(negedge sys_clk) begin
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_en", {31'b0, mem_wr_en}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] store cycle %0d addr %h data %h", cyc, mem_addr, mem_data_in);
                check("store_addr", mem_addr, e.addr);
                check("store_data", mem_data_in, e.data);
                if (e.at_cyc != 0) check("store_cycle", cyc, e.at_cyc);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    // Two-cycle reset; outputs checked while reset is held. Returns at the
    // negedge inside cycle 1 with reset just released.
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        sys_rst = 1'b0;
    endtask

    task automatic finish_run(input string name, input int n_cycles);
        repeat (n_cycles) @(negedge sys_clk);
        check({name, "_writes_seen"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        sys_rst = 1'b1;
        clear_mem();

        // ALU write-back: addi, addi, add, sw
        mem[0] = 32'h00500093;  // addi x1,x0,5
        mem[1] = 32'h00700113;  // addi x2,x0,7
        mem[2] = 32'h002081B3;  // add  x3,x1,x2
        mem[3] = 32'h04302023;  // sw   x3,0x40(x0)
        mem[4] = 32'h0000006F;  // jal  x0,0
        expect_wr(32'h40, 32'd12, 16);
        do_reset();
        #1 check("first_fetch_addr", mem_addr, 32'h0);
        repeat (4) @(negedge sys_clk);
        check("second_fetch_addr", mem_addr, 32'h4);
        finish_run("alu", 20);
        check("alu_mem_word", mem[16], 32'd12);

        // Load/store round trip
        clear_mem();
        mem[0]  = 32'h04002203; // lw x4,0x40(x0)
        mem[1]  = 32'h04402223; // sw x4,0x44(x0)
        mem[2]  = 32'h0000006F;
        mem[16] = 32'hDEADBEEF;
        expect_wr(32'h44, 32'hDEADBEEF, 9);
        do_reset();
        finish_run("ldst", 14);
        check("ldst_mem_word", mem[17], 32'hDEADBEEF);

        // Branches: beq taken skips addi x7; bne falls through to addi x8
        clear_mem();
        mem[0] = 32'h00300093;  // addi x1,x0,3
        mem[1] = 32'h00300113;  // addi x2,x0,3
        mem[2] = 32'h00208463;  // beq  x1,x2,+8
        mem[3] = 32'h00100393;  // addi x7,x0,1 (skipped)
        mem[4] = 32'h00209463;  // bne  x1,x2,+8 (not taken)
        mem[5] = 32'h00100413;  // addi x8,x0,1
        mem[6] = 32'h04702023;  // sw   x7,0x40(x0)
        mem[7] = 32'h04802223;  // sw   x8,0x44(x0)
        mem[8] = 32'h0000006F;
        mem[16] = 32'hFFFFFFFF;
        mem[17] = 32'hFFFFFFFF;
        expect_wr(32'h40, 32'd0, 22);
        expect_wr(32'h44, 32'd1, 26);
        do_reset();
        finish_run("branch", 30);

        // Jump: NOPs up to 0x20, then jal x5,+12 skipping two addi
        clear_mem();
        mem[8]  = 32'h00C002EF; // jal  x5,+12
        mem[9]  = 32'h00100293; // addi x5,x0,1 (skipped)
        mem[10] = 32'h00100293; // addi x5,x0,1 (skipped)
        mem[11] = 32'h04502023; // sw   x5,0x40(x0)
        mem[12] = 32'h0000006F;
        expect_wr(32'h40, 32'h24, 0);
        do_reset();
        finish_run("jal", 30);

        // Signed compare, subtract, x0 discard
        clear_mem();
        mem[0] = 32'hFFD00093;  // addi x1,x0,-3
        mem[1] = 32'h0000A133;  // slt  x2,x1,x0
        mem[2] = 32'h40100333;  // sub  x6,x0,x1
        mem[3] = 32'h00900013;  // addi x0,x0,9
        mem[4] = 32'h04202023;  // sw   x2,0x40(x0)
        mem[5] = 32'h04602223;  // sw   x6,0x44(x0)
        mem[6] = 32'h04002423;  // sw   x0,0x48(x0)
        mem[7] = 32'h0000006F;
        mem[18] = 32'hFFFFFFFF;
        expect_wr(32'h40, 32'd1, 20);
        expect_wr(32'h44, 32'd3, 24);
        expect_wr(32'h48, 32'd0, 28);
        do_reset();
        finish_run("signed", 32);

        // Logic ops and slti
        clear_mem();
        mem[0]  = 32'h05A00093; // addi x1,x0,0x5A
        mem[1]  = 32'h0FF0C113; // xori x2,x1,0xFF   -> 0xA5
        mem[2]  = 32'h1000E193; // ori  x3,x1,0x100  -> 0x15A
        mem[3]  = 32'h00F0F213; // andi x4,x1,0xF    -> 0x0A
        mem[4]  = 32'h0600A293; // slti x5,x1,0x60   -> 1
        mem[5]  = 32'h00314333; // xor  x6,x2,x3     -> 0x1FF
        mem[6]  = 32'h004163B3; // or   x7,x2,x4     -> 0xAF
        mem[7]  = 32'h0041F433; // and  x8,x3,x4     -> 0x0A
        mem[8]  = 32'h04602023; // sw   x6,0x40(x0)
        mem[9]  = 32'h04702223; // sw   x7,0x44(x0)
        mem[10] = 32'h04802423; // sw   x8,0x48(x0)
        mem[11] = 32'h04502623; // sw   x5,0x4C(x0)
        mem[12] = 32'h0000006F;
        expect_wr(32'h40, 32'h1FF, 36);
        expect_wr(32'h44, 32'hAF, 40);
        expect_wr(32'h48, 32'h0A, 44);
        expect_wr(32'h4C, 32'd1, 48);
        do_reset();
        finish_run("logic", 52);

        // Reset during the MEMWRITE cycle aborts the store
        clear_mem();
        mem[0]  = 32'h00500093;
        mem[1]  = 32'h00700113;
        mem[2]  = 32'h002081B3;
        mem[3]  = 32'h04302023;
        mem[4]  = 32'h0000006F;
        mem[16] = 32'h0BADF00D;
        do_reset();
        repeat (14) @(negedge sys_clk);   // negedge of cycle 15
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;                // cycle 16 would be MEMWRITE
        @(negedge sys_clk);
        check("abort_wr_en", {31'b0, mem_wr_en}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("abort_mem_word", mem[16], 32'h0BADF00D);
        repeat (4) @(negedge sys_clk);
        check("abort_restart_fetch", mem_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
